// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning path.
package button_pkg;

  // Per-channel hold-to-repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Bit positions of the buttons on every 3-bit button bus.
  localparam int BTN_NEXT    = 0;
  localparam int BTN_OK      = 1;
  localparam int BTN_PREV    = 2;
  localparam int NUM_BUTTONS = 3;

  // Larger of two cycle counts; sizes the shared repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce, press pulse and optional hold-to-repeat.
module button_channel
  import button_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES      = 120000,
  parameter int   REPEAT_DELAY_CYCLES  = 6000000,
  parameter int   REPEAT_PERIOD_CYCLES = 1200000,
  parameter logic REPEAT_EN            = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic button_async_unsafe_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCNT_W  = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES) + 1);

  // Terminal values: the counter is one short of the target on the cycle the event fires.
  localparam logic [CNT_W-1:0]  DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_ZERO   = {RCNT_W{1'b0}};
  localparam logic [RCNT_W-1:0] RCNT_ONE    = {{(RCNT_W-1){1'b0}}, 1'b1};

  logic              meta_q;
  logic              sync_q;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              level_q, level_d;
  logic              pulse_q, pulse_d;
  logic [RCNT_W-1:0] rcnt_q,  rcnt_d;
  rpt_state_e        state_q, state_d;
  logic              rise_s;
  logic              fall_s;

  // Two synchronizer stages; only sync_q is used downstream.
  dff u_sync_meta (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (button_async_unsafe_i),
    .q_o     (meta_q)
  );

  dff u_sync_stable (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (meta_q),
    .q_o     (sync_q)
  );

  // Debounce: count consecutive disagreeing cycles, adopt the synced level after the full run.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync_q;
        cnt_d   = CNT_ZERO;
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  assign rise_s = ~level_q &  level_d;
  assign fall_s =  level_q & ~level_d;

  // Repeat FSM next state and pulse; a release always wins over a due repeat pulse.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    pulse_d = 1'b0;
    if (fall_s) begin
      state_d = IDLE;
      rcnt_d  = RCNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          rcnt_d = RCNT_ZERO;
          if (rise_s) begin
            pulse_d = 1'b1;
            state_d = REPEAT_EN ? HOLD : IDLE;
          end else begin
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (rcnt_q == DELAY_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = RCNT_ZERO;
            state_d = REPEAT;
          end else begin
            rcnt_d  = rcnt_q + RCNT_ONE;
          end
        end
        REPEAT: begin
          if (rcnt_q == PERIOD_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = RCNT_ZERO;
          end else begin
            rcnt_d  = rcnt_q + RCNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = RCNT_ZERO;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rcnt_q  <= RCNT_ZERO;
      state_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/dff.sv
// Single-bit D flip-flop with synchronous active-high reset.
module dff (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  // Capture d_i each cycle, clear on reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw next/ok/prev buttons into debounced levels and press/repeat pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int                     DEBOUNCE_CYCLES      = 120000,
  parameter int                     REPEAT_DELAY_CYCLES  = 6000000,
  parameter int                     REPEAT_PERIOD_CYCLES = 1200000,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK          = 3'b101
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_BUTTONS-1:0] button_async_unsafe_i,
  output logic [NUM_BUTTONS-1:0] level_o,
  output logic [NUM_BUTTONS-1:0] pulse_o
);

  // Reject parameter sets the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY_CYCLES < 2) begin : g_bad_delay
    $error("button_conditioner: REPEAT_DELAY_CYCLES must be >= 2");
  end
  if (REPEAT_PERIOD_CYCLES < 2) begin : g_bad_period
    $error("button_conditioner: REPEAT_PERIOD_CYCLES must be >= 2");
  end
  if (BTN_NEXT >= NUM_BUTTONS || BTN_OK >= NUM_BUTTONS || BTN_PREV >= NUM_BUTTONS) begin : g_bad_map
    $error("button_conditioner: button index outside the button bus");
  end

  // Fully independent channel per button.
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
      .REPEAT_EN            (REPEAT_MASK[i])
    ) u_chan (
      .clk_i                 (clk_i),
      .reset_i               (reset_i),
      .button_async_unsafe_i (button_async_unsafe_i[i]),
      .level_o               (level_o[i]),
      .pulse_o               (pulse_o[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized + directed bench for button_conditioner against an edge-indexed behavioural model.
module tb_button_conditioner;

  localparam int         DB     = 4;
  localparam int         DELAY  = 10;
  localparam int         PERIOD = 5;
  localparam logic [2:0] MASK   = 3'b101;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [2:0] level;
  logic [2:0] pulse;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES      (DB),
    .REPEAT_DELAY_CYCLES  (DELAY),
    .REPEAT_PERIOD_CYCLES (PERIOD),
    .REPEAT_MASK          (MASK)
  ) dut (
    .clk_i                 (clk),
    .reset_i               (rst),
    .button_async_unsafe_i (btn),
    .level_o               (level),
    .pulse_o               (pulse)
  );

  int tests = 0;
  int fails = 0;

  // Model: edge counter, synced-value history (index 0 = value after the latest edge),
  // last raw sample, per-channel press edge, expected outputs after the latest edge.
  int         edge_n = 0;
  logic [2:0] win [DB];
  logic [2:0] raw_prev = 3'b000;
  int         press_edge [3];
  logic [2:0] m_level = 3'b000;
  logic [2:0] m_pulse = 3'b000;
  int         plog_edge [$];
  int         plog_ch [$];
  int         offs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [2:0] b);
    logic old_l, new_l, p, all_diff;
    int   d;
    if (r) begin
      m_level  = 3'b000;
      m_pulse  = 3'b000;
      raw_prev = 3'b000;
      for (int j = 0; j < DB; j++) win[j] = 3'b000;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        old_l    = m_level[ch];
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) if (win[j][ch] == old_l) all_diff = 1'b0;
        new_l = all_diff ? ~old_l : old_l;
        p     = 1'b0;
        if (!old_l && new_l) begin
          press_edge[ch] = edge_n;
          p = 1'b1;
        end else if (old_l && new_l) begin
          d = edge_n - press_edge[ch];
          p = MASK[ch] && (d >= DELAY) && (((d - DELAY) % PERIOD) == 0);
        end
        m_level[ch] = new_l;
        m_pulse[ch] = p;
        if (p) begin
          plog_edge.push_back(edge_n);
          plog_ch.push_back(ch);
        end
      end
      for (int j = DB - 1; j > 0; j--) win[j] = win[j-1];
      win[0]   = raw_prev;
      raw_prev = b;
    end
  endtask

  // Drive at the falling edge, let the DUT and model take the rising edge, compare at the next fall.
  task automatic tick(input logic r, input logic [2:0] b);
    rst = r;
    btn = b;
    @(posedge clk);
    edge_n++;
    model_step(r, b);
    @(negedge clk);
    check("level", {29'd0, level}, {29'd0, m_level});
    check("pulse", {29'd0, pulse}, {29'd0, m_pulse});
  endtask

  task automatic clear_log();
    plog_edge.delete();
    plog_ch.delete();
  endtask

  // Hand-computed pulse edges (relative to base) for one channel.
  task automatic check_log(input string name, input int ch, input int base);
    int act [$];
    for (int i = 0; i < plog_edge.size(); i++)
      if (plog_ch[i] == ch) act.push_back(plog_edge[i] - base);
    check({name, " count"}, act.size(), offs.size());
    for (int i = 0; i < act.size() && i < offs.size(); i++)
      check({name, " edge"}, act[i], offs[i]);
  endtask

  initial begin
    int k;
    logic [2:0] b;
    logic r;
    for (int j = 0; j < DB; j++) win[j] = 3'b000;
    for (int ch = 0; ch < 3; ch++) press_edge[ch] = 0;
    rst = 1'b1;
    btn = 3'b000;
    @(negedge clk);

    // 1: reset three cycles, then one released cycle, everything zero.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 3'b000);
      check("rst level", {29'd0, level}, 32'd0);
      check("rst pulse", {29'd0, pulse}, 32'd0);
    end
    tick(1'b0, 3'b000);
    check("post-rst pulse", {29'd0, pulse}, 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b0, 3'b000);

    // 2: next held 30 cycles; the fall lands on a due repeat and suppresses it.
    clear_log();
    k = edge_n + 1;
    for (int i = 0; i < 30; i++) tick(1'b0, 3'b001);
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 3'b000);
      if (edge_n == k + 34) check("next level before fall", {31'd0, level[0]}, 32'd1);
      if (edge_n == k + 35) check("next level after fall", {31'd0, level[0]}, 32'd0);
    end
    offs = {5, 15, 20, 25, 30};
    check_log("next repeat", 0, k);

    // 3: ok held 40 cycles, single pulse only.
    clear_log();
    k = edge_n + 1;
    for (int i = 0; i < 40; i++) tick(1'b0, 3'b010);
    for (int i = 0; i < 10; i++) tick(1'b0, 3'b000);
    offs = {5};
    check_log("ok single", 1, k);

    // 4: prev bounces in and out; exactly one pulse, release coincides with a due repeat.
    clear_log();
    for (int i = 0; i < 8; i++) tick(1'b0, (i % 4 < 2) ? 3'b100 : 3'b000);
    k = edge_n + 1;
    for (int i = 0; i < 6; i++) tick(1'b0, 3'b100);
    for (int i = 0; i < 4; i++) tick(1'b0, (i < 2) ? 3'b000 : 3'b100);
    for (int i = 0; i < 12; i++) tick(1'b0, 3'b000);
    offs = {5};
    check_log("prev bounce", 2, k);

    // 5: next and prev together; pulses and repeats coincide.
    clear_log();
    k = edge_n + 1;
    for (int i = 0; i < 25; i++) tick(1'b0, 3'b101);
    for (int i = 0; i < 10; i++) tick(1'b0, 3'b000);
    offs = {5, 15, 20, 25};
    check_log("pair next", 0, k);
    check_log("pair prev", 2, k);

    // 6: reset while next is held; the press restarts after the reset.
    clear_log();
    k = edge_n + 1;
    for (int i = 0; i < 22; i++) tick(1'b0, 3'b001);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 3'b001);
      check("mid-hold rst level", {29'd0, level}, 32'd0);
      check("mid-hold rst pulse", {29'd0, pulse}, 32'd0);
    end
    for (int i = 0; i < 30; i++) tick(1'b0, 3'b001);
    for (int i = 0; i < 10; i++) tick(1'b0, 3'b000);
    offs = {5, 15, 20, 29, 39, 44, 49, 54};
    check_log("reset mid-hold", 0, k);

    // Random phase: slow random toggling with rare resets, model-checked every cycle.
    b = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 3; ch++)
        if ($urandom_range(0, 11) == 0) b[ch] = ~b[ch];
      r = ($urandom_range(0, 399) == 0);
      tick(r, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
